// File: rtl/scan_decoder_onehot.sv
// Registered one-hot line selector with direct decode and prescaled scan modes.
// Define SCAN_BLANK_EN to insert a blank slot between scan lines.
module scan_decoder_onehot #(
  parameter int SEL_W    = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      d,
  output logic [2**SEL_W-1:0]   q,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int N  = 2**SEL_W;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    pc;
  logic [SEL_W-1:0] idx_nxt;
  logic             last;
  logic             slot_end;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] c);
    return N'(1) << c;
  endfunction

  assign idx_nxt  = idx + SEL_W'(1);
  assign last     = &idx;
  assign slot_end = (pc == PW'(PRESCALE - 1));

`ifdef SCAN_BLANK_EN
  typedef enum logic {SCAN, BLANK} state_t;
  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
      pc    <= '0;
      state <= SCAN;
    end else if (!en) begin
      wrap <= 1'b0;
    end else if (mode) begin
      idx   <= d;
      q     <= onehot(d);
      pc    <= '0;
      wrap  <= 1'b0;
      state <= SCAN;
    end else if (state == BLANK) begin
      idx   <= idx_nxt;
      q     <= onehot(idx_nxt);
      wrap  <= last;
      state <= SCAN;
    end else if (!slot_end) begin
      pc   <= pc + PW'(1);
      q    <= onehot(idx);
      wrap <= 1'b0;
    end else begin
      // dark slot between lines suppresses ghosting
      pc    <= '0;
      q     <= '0;
      wrap  <= 1'b0;
      state <= BLANK;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      idx  <= '0;
      wrap <= 1'b0;
      pc   <= '0;
    end else if (!en) begin
      wrap <= 1'b0;
    end else if (mode) begin
      idx  <= d;
      q    <= onehot(d);
      pc   <= '0;
      wrap <= 1'b0;
    end else if (!slot_end) begin
      pc   <= pc + PW'(1);
      q    <= onehot(idx);
      wrap <= 1'b0;
    end else begin
      pc   <= '0;
      idx  <= idx_nxt;
      q    <= onehot(idx_nxt);
      wrap <= last;
    end
  end
`endif

endmodule
